ipgu_window_fetch: RTL
======================

IPGU_WINDOW_FETCH -- requirements
Module: ipgu_window_fetch

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL have parameter WIN, default 20, window edge in pixels.
REQ-003 SHALL have parameter RD_LAT, default 2, cycles from incX to matching ramData.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins one image pass.
REQ-007 SHALL have port numWindows  input  4  image size in 20-pixel units; sampled on accepted start.
REQ-008 SHALL have port ramData  input  PIX_W  pixel read from image RAM, valid RD_LAT cycles after its incX.
REQ-009 SHALL have port incX  output  1  advance pixel address to the address generator.
REQ-010 SHALL have port windowDone  output  1  pulse that moves the address generator to the next window.
REQ-011 SHALL have port busy  output  1  high from accepted start until done.
REQ-012 SHALL have port rowValid  output  1  a window row is presented.
REQ-013 SHALL have port rowReady  input  1  downstream accepts the row.
REQ-014 SHALL have port rowData  output  WIN*PIX_W  one window row; column 0 in bits [PIX_W-1:0].
REQ-015 SHALL have port rowIdx  output  5  row number 0..WIN-1 of rowData.
REQ-016 SHALL have port lastWindow  output  1  high while the final window of the pass is being sent.
REQ-017 SHALL have port done  output  1  single-cycle pulse at the end of the pass.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN, SEND.
REQ-019 SHALL leave IDLE for FETCH on start when numWindows != 0, latching numWindows and setting busy the next cycle.
REQ-020 SHALL stay in IDLE on start with numWindows == 0, pulse done one cycle later, and never assert busy.
REQ-021 SHALL ignore start in all states other than IDLE.
REQ-022 SHALL compute windows per pass as (2*N-1)^2, with N the latched numWindows (stride-10 overlap); the window counter SHALL be 10 bits.
REQ-023 In FETCH, SHALL assert incX every cycle for exactly WIN*WIN cycles, counted by a 9-bit issue counter.
REQ-024 SHALL assert windowDone in the same cycle as the final (400th) incX of each window, and at no other time.
REQ-025 SHALL enter DRAIN after the final incX and stay until all WIN*WIN pixels are captured, which is RD_LAT cycles.
REQ-026 SHALL capture ramData into the window buffer in cycles where the RD_LAT-deep shifted copy of incX is 1.
REQ-027 Captured pixel k (0-based) SHALL be stored at row k/WIN, column k%WIN, in raster order.
REQ-028 SHALL enter SEND when capture completes, with rowValid=1 and rowIdx=0.
REQ-029 SHALL hold rowData, rowIdx and rowValid stable while rowValid && !rowReady.
REQ-030 On rowValid && rowReady SHALL advance rowIdx by 1, with no bubble between rows.
REQ-031 On acceptance of row WIN-1, SHALL deassert rowValid the next cycle and return to FETCH if windows remain.
REQ-032 On acceptance of row WIN-1 of the last window, SHALL go to IDLE, pulse done for one cycle, and deassert busy in that same cycle.
REQ-033 SHALL assert lastWindow only in SEND of window (2N-1)^2-1.
REQ-034 SHALL keep incX=0 in DRAIN, SEND and IDLE; fetch and send SHALL NOT overlap (single buffer).

Reset
REQ-035 When rst=1 at a clock edge, SHALL force IDLE and clear all counters and the incX delay line.
REQ-036 After reset, all outputs SHALL read 0 (rowData=0, rowIdx=0), including when reset hits mid-FETCH or mid-SEND.
REQ-037 After reset, buffer contents SHALL be don't-care and SHALL NOT be presented until refilled.

Verification
REQ-038 N=1, start, rowReady=1, ramData=pixel index mod 256 -> 400 incX cycles, one windowDone on the 400th, 20 rows with row r col c = (20r+c) mod 256, lastWindow high, one done pulse.
REQ-039 N=2 -> exactly 9 windowDone pulses and 180 accepted rows before done.
REQ-040 N=1 with rowReady toggling 1-of-3 cycles -> rowData/rowIdx stable while stalled, no row lost or duplicated, done after row 19.
REQ-041 start with N=0 -> done one cycle later, incX never asserted, busy stays 0.
REQ-042 rst asserted mid-FETCH (pixel 150), then a new start with N=1 -> all outputs 0 after reset, and a full clean 400-pixel window with correct data.
REQ-043 start pulsed during SEND -> ignored; window count and done timing unchanged.

Source files
------------

// File: rtl/ipgu_window_fetch.sv
// ipgu_window_fetch
// Fetches one WIN x WIN pixel window at a time from image RAM into a single
// window buffer, then streams that window out row by row. A pass over an
// image of N 20-pixel units covers (2N-1)^2 overlapping windows (stride 10).
// Fetch and send never overlap: the buffer is refilled only after the last
// row of the previous window has been accepted.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   start       : one-cycle pulse, begins a pass (honoured only when idle)
//   numWindows  : image size in 20-pixel units, latched on accepted start
//   ramData     : pixel read data, valid RD_LAT cycles after its incX
//   incX        : advance pixel address (one per fetched pixel)
//   windowDone  : coincides with the final incX of each window
//   busy        : high from accepted start until done
//   rowValid/rowReady/rowData/rowIdx : row stream, column 0 in the low bits
//   lastWindow  : high while the final window of the pass is being sent
//   done        : one-cycle pulse at the end of the pass
module ipgu_window_fetch #(
  parameter int PIX_W  = 8,
  parameter int WIN    = 20,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [3:0]           numWindows,
  input  logic [PIX_W-1:0]     ramData,
  output logic                 incX,
  output logic                 windowDone,
  output logic                 busy,
  output logic                 rowValid,
  input  logic                 rowReady,
  output logic [WIN*PIX_W-1:0] rowData,
  output logic [4:0]           rowIdx,
  output logic                 lastWindow,
  output logic                 done
);

  localparam logic [8:0] LAST_PIX = 9'(WIN*WIN-1);
  localparam logic [4:0] LAST_POS = 5'(WIN-1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, SEND} state_t;

  state_t state, state_nxt;

  logic [3:0]          n_lat;
  logic [4:0]          odd;
  logic [9:0]          win_total;
  logic [9:0]          last_win;
  logic [9:0]          win_cnt;
  logic [8:0]          issue_cnt;
  logic [RD_LAT-1:0]   inc_pipe;
  logic [4:0]          cap_row;
  logic [4:0]          cap_col;
  logic [4:0]          row_idx;
  logic                busy_q;
  logic                done_q;

  logic                capture;
  logic                cap_last;
  logic                fetch_last;
  logic                row_acc;
  logic                row_last_acc;
  logic                is_last_win;

  logic [WIN*PIX_W-1:0] rows [WIN];

  // Windows per pass: (2N-1)^2, N <= 15 so the result fits 10 bits.
  assign odd       = {n_lat, 1'b0} - 5'd1;
  assign win_total = {5'd0, odd} * {5'd0, odd};
  assign last_win  = win_total - 10'd1;

  // The oldest stage of the incX delay line marks a cycle whose ramData
  // belongs to a fetched pixel.
  assign capture      = inc_pipe[RD_LAT-1];
  assign cap_last     = capture && (cap_row == LAST_POS) && (cap_col == LAST_POS);
  assign fetch_last   = (state == FETCH) && (issue_cnt == LAST_PIX);
  assign row_acc      = (state == SEND) && rowReady;
  assign row_last_acc = row_acc && (row_idx == LAST_POS);
  assign is_last_win  = (win_cnt == last_win);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start && (numWindows != 4'd0)) state_nxt = FETCH;
      FETCH: if (fetch_last) state_nxt = DRAIN;
      DRAIN: if (cap_last) state_nxt = SEND;
      SEND:  if (row_last_acc) state_nxt = is_last_win ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    incX       = (state == FETCH);
    windowDone = fetch_last;
    rowValid   = (state == SEND);
    lastWindow = (state == SEND) && is_last_win;
    rowIdx     = row_idx;
    busy       = busy_q;
    done       = done_q;
    rowData    = '0;
    // Buffer contents are undefined after reset; expose them only in SEND.
    if (state == SEND) rowData = rows[row_idx];
  end

  // Counters, delay line and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lat     <= '0;
      win_cnt   <= '0;
      issue_cnt <= '0;
      inc_pipe  <= '0;
      cap_row   <= '0;
      cap_col   <= '0;
      row_idx   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      inc_pipe[0] <= (state == FETCH);
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        inc_pipe[i] <= inc_pipe[i-1];
      end

      if (capture) begin
        if (cap_col == LAST_POS) begin
          cap_col <= '0;
          cap_row <= cap_last ? 5'd0 : cap_row + 5'd1;
        end else begin
          cap_col <= cap_col + 5'd1;
        end
      end

      unique case (state)
        IDLE: begin
          if (start) begin
            if (numWindows != 4'd0) begin
              n_lat     <= numWindows;
              busy_q    <= 1'b1;
              win_cnt   <= '0;
              issue_cnt <= '0;
              cap_row   <= '0;
              cap_col   <= '0;
              row_idx   <= '0;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          issue_cnt <= fetch_last ? 9'd0 : issue_cnt + 9'd1;
        end
        DRAIN: ;
        SEND: begin
          if (row_acc) begin
            if (row_idx == LAST_POS) begin
              row_idx <= '0;
              if (is_last_win) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
              end else begin
                win_cnt <= win_cnt + 10'd1;
              end
            end else begin
              row_idx <= row_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Window buffer: pixel k lands at row k/WIN, column k%WIN.
  always_ff @(posedge clk) begin
    if (capture) begin
      rows[cap_row][cap_col*PIX_W +: PIX_W] <= ramData;
    end
  end

endmodule
